cpu_core: RTL and testbench
===========================

# cpu_core

Single-cycle-issue, two-state control core for the Simple CPU. It sits directly upstream of the 256×16 program/data RAM and is the only master on that RAM's port. It fetches 16-bit instructions, decodes a 4-bit opcode and 8-bit operand, and executes against a 16-bit accumulator. It drives the RAM's address, write-enable and write-data. The RAM read path is combinational and has zero latency, so every instruction completes in exactly two clocks.

## Interface
- `ADDR_W`, default 8: RAM address width; also the PC width.
- `DATA_W`, default 16: instruction, data and accumulator width.
- `clk`, input, 1: rising-edge clock shared with the RAM.
- `rst_n`, input, 1: **one clock; reset is asynchronous and active-low.**
- `run`, input, 1: when low, the core holds in FETCH and issues no new instruction.
- `mem_rdata`, input, DATA_W: RAM read data, valid in the same cycle as `mem_addr`.
- `mem_addr`, output, ADDR_W: RAM address.
- `mem_we`, output, 1: RAM write strobe; the write takes effect on the next rising edge.
- `mem_wdata`, output, DATA_W: RAM write data.
- `pc_out`, output, ADDR_W: current program counter.
- `acc_out`, output, DATA_W: accumulator.
- `zero`, output, 1: Z flag.
- `carry`, output, 1: C flag.
- `halted`, output, 1: high once HALT has executed.

## Operation
- Instruction format: `[15:12]` is the opcode, `[11:8]` is ignored, `[7:0]` is the operand `op8`.
- Opcodes:
  - 0x0 NOP.
  - 0x1 LDI: acc = zext(op8).
  - 0x2 STA: mem[op8] = acc.
  - 0x3 ADDI: acc = acc + zext(op8).
  - 0x4 LDA: acc = mem[op8].
  - 0x5 ADDM: acc = acc + mem[op8].
  - 0x6 JZ: pc = op8 if Z = 1.
  - 0x7 JMP: pc = op8.
  - 0xF HALT.
  - 0x8–0xE execute as NOP.
- FSM states are FETCH, EXEC and HALT.
  - FETCH: `mem_addr` = pc. If `run` = 1: ir ← `mem_rdata`, pc ← pc+1 (mod 256), next state EXEC. If `run` = 0: hold.
  - EXEC: `mem_addr` = op8 for STA, LDA and ADDM; otherwise `mem_addr` = pc. Perform the operation and go to FETCH. HALT goes to the HALT state instead.
  - HALT: absorbing state. `halted` = 1, `mem_addr` = pc, `mem_we` = 0. Only `rst_n` exits it.
- `mem_we` = 1 only in EXEC with opcode STA. It is decoded combinationally from state and ir. `mem_wdata` = acc at all times.
- Arithmetic: 17-bit sum, acc ← sum[15:0], C ← sum[16]. Z ← (result == 0).
- Flag updates: LDI and LDA update Z only and leave C unchanged. ADDI and ADDM update both Z and C. All other opcodes leave both flags unchanged.
- PC wrap: pc 0xFF increments to 0x00 with no error.
- JZ/JMP override the FETCH increment. The target is loaded at the end of EXEC.
- STA to the address holding the next instruction is allowed. The new value is fetched, because the write lands before the next FETCH samples.

## Timing
- Reset values: state FETCH, pc 0x00, ir 0x0000, acc 0x0000, Z = 1, C = 0, `halted` 0, `mem_we` 0, `mem_addr` 0x00.
- Reset mid-instruction: everything clears immediately, including `mem_we`, which drops with no clock. The STA write in flight is lost. After `rst_n` deasserts, fetch restarts at 0x00 on the first edge.
- Latency and throughput: every instruction takes 2 clocks (FETCH + EXEC), so throughput is 0.5 IPC with `run` held high.
- `run` is sampled only in FETCH. Deasserting it during EXEC does not abort the instruction; the core stalls at the following FETCH.
- RAM contract: the RAM presents `mem_rdata` combinationally from `mem_addr` in the same cycle. No wait states.

## Structure
- Shared package `cpu_pkg`:
  - opcode localparams (OP_NOP … OP_HALT)
  - state enum (S_FETCH, S_EXEC, S_HALT)
  - field slice constants (OPC_HI/LO, OPR_HI/LO)
  - ADDR_W/DATA_W defaults
- One sub-module, `cpu_alu`: combinational. Takes acc, operand (16-bit) and opcode; returns result, Z, C and a write-acc enable.
- The FSM, PC, IR and flag registers live in `cpu_core`.

## Test plan
- **Reference program loop.** RAM holds 0x1005, 0x3003, 0x20FF, 0x7000. Run 8 clocks → mem[0xFF] = 0x0008, acc = 0x0008, pc = 0x00. `mem_we` high exactly once, in cycle 6, with addr 0xFF.
- **Carry and zero.** LDA of 0xFFFF, then ADDI 0x01 → acc 0x0000, Z = 1, C = 1. A following JZ 0x40 → pc 0x40 after 2 more clocks.
- **Memory operand path.** mem[0x80] = 0x000A. Run LDI 3, ADDM 0x80, STA 0x81 → mem[0x81] = 0x000D. Also confirm Z = 0 and C unchanged after LDI.
- **PC wrap and unused opcodes.** Place 0x8123 at 0xFF, start at 0xFF via JMP → it executes as NOP, and the next fetch address is 0x00.
- **Halt and run gating.**
  - HALT → `halted` = 1; pc, acc and `mem_we` are frozen for 20 clocks.
  - Separately, `run` = 0 in FETCH for 5 clocks → no state change. `run` dropped in EXEC → the instruction still completes.
- **Async reset mid-STA.** Assert `rst_n` = 0 during the STA EXEC cycle, between edges → `mem_we` falls immediately, the target word is unchanged, and all outputs are at reset values.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the Simple CPU: widths, opcodes, instruction fields,
// FSM states and the debug view of the control core.
package cpu_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 16;

   localparam int OPC_HI = 15;
   localparam int OPC_LO = 12;
   localparam int OPR_HI = 7;
   localparam int OPR_LO = 0;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_STA  = 4'h2;
   localparam logic [3:0] OP_ADDI = 4'h3;
   localparam logic [3:0] OP_LDA  = 4'h4;
   localparam logic [3:0] OP_ADDM = 4'h5;
   localparam logic [3:0] OP_JZ   = 4'h6;
   localparam logic [3:0] OP_JMP  = 4'h7;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_HALT  = 2'd2
   } state_t;

   typedef struct packed {
      state_t                  state;
      logic [DATA_W_DEF-1:0]   ir;
   } dbg_t;

endpackage

// File: rtl/cpu_if.sv
// RAM port between the control core (master) and the 256x16 program/data RAM.
interface cpu_if import cpu_pkg::*; #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   // No valid/ready: mem_rdata follows mem_addr combinationally in the same
   // cycle, and a cycle with mem_we high commits mem_wdata on the next rising edge.
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (output mem_addr, mem_we, mem_wdata, input mem_rdata);
   modport slave  (input mem_addr, mem_we, mem_wdata, output mem_rdata);
endinterface

// File: rtl/cpu_alu.sv
// Combinational accumulator ALU: load and add operations with Z/C flag results.
module cpu_alu import cpu_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [DATA_W-1:0] acc,
   input  logic [DATA_W-1:0] operand,
   input  logic [3:0]        opc,
   input  logic              z_in,
   input  logic              c_in,
   output logic [DATA_W-1:0] result,
   output logic              z,
   output logic              c,
   output logic              acc_we
);
   logic [DATA_W:0] sum;

   assign sum = {1'b0, acc} + {1'b0, operand};

   // Flags pass through unchanged for opcodes that do not touch them.
   always_comb begin
      result = acc;
      z      = z_in;
      c      = c_in;
      acc_we = 1'b0;
      case (opc)
         OP_LDI, OP_LDA: begin
            result = operand;
            z      = (operand == '0);
            acc_we = 1'b1;
         end
         OP_ADDI, OP_ADDM: begin
            result = sum[DATA_W-1:0];
            z      = (sum[DATA_W-1:0] == '0);
            c      = sum[DATA_W];
            acc_we = 1'b1;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/cpu_core.sv
// Two-state (FETCH/EXEC) accumulator control core; sole master of the RAM port.
module cpu_core import cpu_pkg::*; #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   cpu_if.master             mem,
   output logic [ADDR_W-1:0] pc_out,
   output logic [DATA_W-1:0] acc_out,
   output logic              zero,
   output logic              carry,
   output logic              halted,
   output dbg_t              dbg
);
   state_t            state, state_nx;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] ir, acc;
   logic              zf, cf;
   logic [3:0]        opc;
   logic [7:0]        op8;
   logic              mem_operand;
   logic [DATA_W-1:0] operand;
   logic [DATA_W-1:0] alu_result;
   logic              alu_z, alu_c, alu_acc_we;

   assign opc         = ir[OPC_HI:OPC_LO];
   assign op8         = ir[OPR_HI:OPR_LO];
   assign mem_operand = (opc == OP_LDA) || (opc == OP_ADDM);
   assign operand     = mem_operand ? mem.mem_rdata : DATA_W'(op8);

   cpu_alu #(.DATA_W(DATA_W)) u_alu (
      .acc     (acc),
      .operand (operand),
      .opc     (opc),
      .z_in    (zf),
      .c_in    (cf),
      .result  (alu_result),
      .z       (alu_z),
      .c       (alu_c),
      .acc_we  (alu_acc_we)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_FETCH;
      else        state <= state_nx;
   end

   // mem_we is decoded from state, so it drops the instant reset forces FETCH.
   always_comb begin
      state_nx      = state;
      mem.mem_addr  = pc;
      mem.mem_we    = 1'b0;
      case (state)
         S_FETCH: if (run) state_nx = S_EXEC;
         S_EXEC: begin
            state_nx = (opc == OP_HALT) ? S_HALT : S_FETCH;
            if (mem_operand || (opc == OP_STA)) mem.mem_addr = ADDR_W'(op8);
            mem.mem_we = (opc == OP_STA);
         end
         default: state_nx = state;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc  <= '0;
         ir  <= DATA_W'({OP_NOP, 12'h000});
         acc <= '0;
         zf  <= 1'b1;
         cf  <= 1'b0;
      end else begin
         case (state)
            S_FETCH: if (run) begin
               ir <= mem.mem_rdata;
               pc <= pc + ADDR_W'(1);
            end
            S_EXEC: begin
               if (alu_acc_we) acc <= alu_result;
               zf <= alu_z;
               cf <= alu_c;
               // Jump targets replace the increment already applied in FETCH.
               if ((opc == OP_JMP) || ((opc == OP_JZ) && zf)) pc <= ADDR_W'(op8);
            end
            default: ;
         endcase
      end
   end

   assign mem.mem_wdata = acc;
   assign pc_out        = pc;
   assign acc_out       = acc;
   assign zero          = zf;
   assign carry         = cf;
   assign halted        = (state == S_HALT);
   assign dbg.state     = state;
   assign dbg.ir        = DATA_W_DEF'(ir);
endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: directed scenarios plus random programs
// checked against an instruction-level model of the CPU.
module tb_cpu_core;
   import cpu_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic run   = 1'b0;
   always #5 clk = ~clk;

   cpu_if #(.ADDR_W(8), .DATA_W(16)) bus ();

   logic [7:0]  pc_out;
   logic [15:0] acc_out;
   logic        zero, carry, halted;
   dbg_t        dbg;

   cpu_core #(.ADDR_W(8), .DATA_W(16)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (run),
      .mem     (bus.master),
      .pc_out  (pc_out),
      .acc_out (acc_out),
      .zero    (zero),
      .carry   (carry),
      .halted  (halted),
      .dbg     (dbg)
   );

   // ---------------- RAM with bench load port ----------------
   logic [15:0] ram [256];
   logic        clr_req = 1'b0;
   logic        ld_en   = 1'b0;
   logic [7:0]  ld_a    = 8'h00;
   logic [15:0] ld_d    = 16'h0000;

   always @(posedge clk) begin
      if (clr_req) begin
         for (int i = 0; i < 256; i++) ram[i] <= 16'h0000;
      end else if (ld_en) begin
         ram[ld_a] <= ld_d;
      end else if (bus.mem_we) begin
         ram[bus.mem_addr] <= bus.mem_wdata;
      end
   end
   assign bus.mem_rdata = ram[bus.mem_addr];

   // ---------------- instruction-level reference model ----------------
   logic [15:0] m_mem [256];
   logic [7:0]  m_pc;
   logic [15:0] m_acc;
   logic        m_z, m_c, m_halted;
   logic [26:0] exp_q [$];

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic iss_step();
      logic [15:0] ins, b;
      logic [3:0]  o;
      logic [7:0]  a;
      logic [16:0] s;
      if (m_halted) return;
      ins  = m_mem[m_pc];
      o    = ins[15:12];
      a    = ins[7:0];
      m_pc = m_pc + 8'd1;
      case (o)
         4'h1: begin m_acc = {8'h00, a}; m_z = (m_acc == 16'h0); end
         4'h2: m_mem[a] = m_acc;
         4'h3, 4'h5: begin
            b     = (o == 4'h3) ? {8'h00, a} : m_mem[a];
            s     = {1'b0, m_acc} + {1'b0, b};
            m_acc = s[15:0];
            m_c   = s[16];
            m_z   = (m_acc == 16'h0);
         end
         4'h4: begin m_acc = m_mem[a]; m_z = (m_acc == 16'h0); end
         4'h6: if (m_z) m_pc = a;
         4'h7: m_pc = a;
         4'hF: m_halted = 1'b1;
         default: ;
      endcase
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic hold_reset();
      rst_n   = 1'b0;
      run     = 1'b0;
      clr_req = 1'b1;
      for (int i = 0; i < 256; i++) m_mem[i] = 16'h0000;
      @(negedge clk);
      clr_req = 1'b0;
   endtask

   task automatic poke(input logic [7:0] a, input logic [15:0] d);
      ld_en    = 1'b1;
      ld_a     = a;
      ld_d     = d;
      m_mem[a] = d;
      @(negedge clk);
      ld_en    = 1'b0;
   endtask

   task automatic release_run();
      m_pc = 8'h00; m_acc = 16'h0000; m_z = 1'b1; m_c = 1'b0; m_halted = 1'b0;
      rst_n = 1'b1;
      run   = 1'b1;
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, ".pc"},     32'(pc_out),       32'h00);
      chk({tag, ".acc"},    32'(acc_out),      32'h0000);
      chk({tag, ".zero"},   32'(zero),         32'h1);
      chk({tag, ".carry"},  32'(carry),        32'h0);
      chk({tag, ".halted"}, 32'(halted),       32'h0);
      chk({tag, ".we"},     32'(bus.mem_we),   32'h0);
      chk({tag, ".addr"},   32'(bus.mem_addr), 32'h00);
      chk({tag, ".state"},  32'(dbg.state),    32'(S_FETCH));
      chk({tag, ".ir"},     32'(dbg.ir),       32'h0000);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int          we_cnt, we_cyc, bad;
      logic [7:0]  we_addr;
      logic [15:0] w;
      logic [26:0] e;

      // Reset state
      hold_reset();
      chk_reset_values("reset");

      // Reference program loop
      hold_reset();
      poke(8'h00, 16'h1005); poke(8'h01, 16'h3003);
      poke(8'h02, 16'h20FF); poke(8'h03, 16'h7000);
      release_run();
      we_cnt = 0; we_cyc = 0; we_addr = 8'h00;
      for (int c = 1; c <= 8; c++) begin
         #1;
         if (bus.mem_we) begin we_cnt++; we_cyc = c; we_addr = bus.mem_addr; end
         @(negedge clk);
      end
      chk("loop.memFF",   32'(ram[8'hFF]), 32'h0008);
      chk("loop.acc",     32'(acc_out),    32'h0008);
      chk("loop.pc",      32'(pc_out),     32'h00);
      chk("loop.we_cnt",  32'(we_cnt),     32'd1);
      chk("loop.we_cyc",  32'(we_cyc),     32'd6);
      chk("loop.we_addr", 32'(we_addr),    32'hFF);

      // Carry and zero, then JZ taken
      hold_reset();
      poke(8'h00, 16'h4010); poke(8'h01, 16'h3001); poke(8'h02, 16'h6040);
      poke(8'h10, 16'hFFFF);
      release_run();
      step(4);
      chk("cz.acc",   32'(acc_out), 32'h0000);
      chk("cz.zero",  32'(zero),    32'h1);
      chk("cz.carry", 32'(carry),   32'h1);
      step(2);
      chk("cz.jz_pc", 32'(pc_out),  32'h40);

      // Memory operand path; LDI must leave C alone
      hold_reset();
      poke(8'h00, 16'h4082); poke(8'h01, 16'h3001); poke(8'h02, 16'h1003);
      poke(8'h03, 16'h5080); poke(8'h04, 16'h2081);
      poke(8'h80, 16'h000A); poke(8'h82, 16'hFFFF);
      release_run();
      step(4);
      chk("mop.carry_set", 32'(carry),   32'h1);
      step(2);
      chk("mop.ldi_acc",   32'(acc_out), 32'h0003);
      chk("mop.ldi_zero",  32'(zero),    32'h0);
      chk("mop.ldi_carry", 32'(carry),   32'h1);
      step(2);
      chk("mop.addm_acc",  32'(acc_out), 32'h000D);
      chk("mop.addm_c",    32'(carry),   32'h0);
      step(2);
      chk("mop.mem81",     32'(ram[8'h81]), 32'h000D);

      // PC wrap through an unused opcode
      hold_reset();
      poke(8'h00, 16'h70FF); poke(8'hFF, 16'h8123);
      release_run();
      step(2);
      chk("wrap.pc_ff", 32'(pc_out),       32'hFF);
      step(2);
      chk("wrap.pc_00", 32'(pc_out),       32'h00);
      chk("wrap.addr",  32'(bus.mem_addr), 32'h00);
      chk("wrap.acc",   32'(acc_out),      32'h0000);
      chk("wrap.state", 32'(dbg.state),    32'(S_FETCH));

      // HALT freezes the core
      hold_reset();
      poke(8'h00, 16'h1007); poke(8'h01, 16'hF000);
      release_run();
      step(4);
      chk("halt.halted", 32'(halted),    32'h1);
      chk("halt.pc",     32'(pc_out),    32'h02);
      chk("halt.acc",    32'(acc_out),   32'h0007);
      chk("halt.state",  32'(dbg.state), 32'(S_HALT));
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (pc_out !== 8'h02 || acc_out !== 16'h0007 || bus.mem_we !== 1'b0 ||
             halted !== 1'b1 || bus.mem_addr !== 8'h02) bad++;
      end
      chk("halt.frozen20", 32'(bad), 32'd0);

      // run gating in FETCH and EXEC
      hold_reset();
      poke(8'h00, 16'h1009);
      release_run();
      run = 1'b0;
      step(5);
      chk("run.stall_pc",    32'(pc_out),    32'h00);
      chk("run.stall_acc",   32'(acc_out),   32'h0000);
      chk("run.stall_state", 32'(dbg.state), 32'(S_FETCH));
      run = 1'b1;
      step(1);
      chk("run.exec_state",  32'(dbg.state), 32'(S_EXEC));
      run = 1'b0;
      step(1);
      chk("run.exec_acc",    32'(acc_out),   32'h0009);
      chk("run.exec_pc",     32'(pc_out),    32'h01);
      step(3);
      chk("run.hold_pc",     32'(pc_out),    32'h01);
      chk("run.hold_state",  32'(dbg.state), 32'(S_FETCH));

      // Async reset in the middle of a STA execute cycle
      hold_reset();
      poke(8'h00, 16'h1055); poke(8'h01, 16'h2090); poke(8'h90, 16'h1234);
      release_run();
      step(3);
      chk("arst.pre_we",   32'(bus.mem_we),   32'h1);
      chk("arst.pre_addr", 32'(bus.mem_addr), 32'h90);
      #2 rst_n = 1'b0;
      #1;
      chk_reset_values("arst");
      @(negedge clk);
      chk("arst.mem90", 32'(ram[8'h90]), 32'h1234);
      rst_n = 1'b1;
      step(2);
      chk("arst.restart_acc", 32'(acc_out), 32'h0055);
      chk("arst.restart_pc",  32'(pc_out),  32'h01);

      // Random programs against the reference model
      for (int p = 0; p < 5; p++) begin
         hold_reset();
         for (int a = 0; a < 256; a++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hF && $urandom_range(0, 7) != 0) w[15:12] = 4'h3;
            poke(8'(a), w);
         end
         release_run();
         for (int i = 0; i < 40; i++) begin
            step(2);
            iss_step();
            exp_q.push_back({m_halted, m_c, m_z, m_pc, m_acc});
            e = exp_q.pop_front();
            chk("rnd.acc",    32'(acc_out), 32'(e[15:0]));
            chk("rnd.pc",     32'(pc_out),  32'(e[23:16]));
            chk("rnd.zero",   32'(zero),    32'(e[24]));
            chk("rnd.carry",  32'(carry),   32'(e[25]));
            chk("rnd.halted", 32'(halted),  32'(e[26]));
         end
         bad = 0;
         for (int a = 0; a < 256; a++) if (ram[a] !== m_mem[a]) bad++;
         chk("rnd.mem_image", 32'(bad), 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
